// File: rtl/ws_frame_sched.sv
// ws_frame_sched: fixed-priority frame scheduler in front of the ws2812b driver.
// Requesters 0 (challenge), 1 (opener), 2 (error flash); bit 2 wins.
// The winning frame is latched and sent once with a LOAD/DONE handshake.
// It is then held for a minimum dwell and re-sent after a long idle period.
// Optional statistics outputs are compiled in with FRAME_SCHED_STATS_EN.
module ws_frame_sched #(
    parameter int HOLD_CYCLES    = 1000,
    parameter int REFRESH_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [2:0]   REQ,
    input  logic [255:0] FRAME0,
    input  logic [255:0] FRAME1,
    input  logic [255:0] FRAME2,
    output logic [2:0]   GNT,
    output logic [1:0]   OWNER,
    output logic [255:0] W_OUT,
    output logic         LOAD,
    input  logic         DONE,
    output logic         TIMEOUT
`ifdef FRAME_SCHED_STATS_EN
    ,
    output logic [15:0]  FRAME_CNT,
    output logic [7:0]   PREEMPT_CNT
`endif
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [HW-1:0]   hold_cnt_r;
    logic [RW-1:0]   refresh_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    // Set by reset so the blank frame is pushed to the driver once after release.
    logic            init_r;

    logic [1:0]      winner_s;
    logic [255:0]    winner_frame_s;
    logic [255:0]    owner_frame_s;
    logic            preempt_s;
    logic            refresh_due_s;
    logic            tmo_hit_s;
    logic            hold_done_s;

    // Frame of a requester index; index 3 (none) selects the blank frame.
    function automatic logic [255:0] sel_frame(input logic [1:0] idx,
                                               input logic [255:0] f0,
                                               input logic [255:0] f1,
                                               input logic [255:0] f2);
        logic [255:0] f;
        case (idx)
            2'd0:    f = f0;
            2'd1:    f = f1;
            2'd2:    f = f2;
            default: f = 256'd0;
        endcase
        return f;
    endfunction

    // One-hot grant vector for an owner index; index 3 grants nobody.
    function automatic logic [2:0] owner_to_gnt(input logic [1:0] idx);
        logic [2:0] g;
        case (idx)
            2'd0:    g = 3'b001;
            2'd1:    g = 3'b010;
            2'd2:    g = 3'b100;
            default: g = 3'b000;
        endcase
        return g;
    endfunction

    // Fixed-priority winner and the conditions the FSM reacts to.
    always_comb begin
        winner_s = 2'd3;
        if (REQ[2]) begin
            winner_s = 2'd2;
        end else if (REQ[1]) begin
            winner_s = 2'd1;
        end else if (REQ[0]) begin
            winner_s = 2'd0;
        end else begin
            winner_s = 2'd3;
        end
        winner_frame_s = sel_frame(winner_s, FRAME0, FRAME1, FRAME2);
        owner_frame_s  = sel_frame(OWNER, FRAME0, FRAME1, FRAME2);
        case (OWNER)
            2'd0:    preempt_s = REQ[2] | REQ[1];
            2'd1:    preempt_s = REQ[2];
            2'd2:    preempt_s = 1'b0;
            default: preempt_s = |REQ;
        endcase
        refresh_due_s = (refresh_cnt_r == REFRESH_LAST);
        tmo_hit_s     = (tmo_cnt_r == TMO_LAST);
        hold_done_s   = (hold_cnt_r == HOLD_LAST);
    end

    // Next-state logic of the scheduling FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (init_r || (winner_s != OWNER) ||
                    (owner_frame_s != W_OUT) || refresh_due_s) begin
                    state_s = S_ARB;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ARB:  state_s = S_LOAD;
            S_LOAD: state_s = S_SEND;
            S_SEND: begin
                // DONE on the final timeout cycle still counts as DONE.
                if (DONE || tmo_hit_s) begin
                    state_s = S_HOLD;
                end else begin
                    state_s = S_SEND;
                end
            end
            S_HOLD: begin
                if (preempt_s) begin
                    state_s = S_ARB;
                end else if (hold_done_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_HOLD;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Dwell, refresh and timeout counters; each clears when its state is left.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_cnt_r    <= {HW{1'b0}};
            refresh_cnt_r <= {RW{1'b0}};
            tmo_cnt_r     <= {TW{1'b0}};
        end else begin
            if (state_r == S_HOLD && state_s == S_HOLD) begin
                hold_cnt_r <= hold_cnt_r + HW'(1);
            end else begin
                hold_cnt_r <= {HW{1'b0}};
            end
            if (state_r == S_IDLE && state_s == S_IDLE) begin
                refresh_cnt_r <= refresh_cnt_r + RW'(1);
            end else begin
                refresh_cnt_r <= {RW{1'b0}};
            end
            if (state_r == S_SEND && state_s == S_SEND) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end else begin
                tmo_cnt_r <= {TW{1'b0}};
            end
        end
    end

    // Latch the winning frame and ownership during arbitration.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            W_OUT  <= 256'd0;
            OWNER  <= 2'd3;
            GNT    <= 3'b000;
            init_r <= 1'b1;
        end else if (state_r == S_ARB) begin
            W_OUT  <= winner_frame_s;
            OWNER  <= winner_s;
            GNT    <= owner_to_gnt(winner_s);
            init_r <= 1'b0;
        end else begin
            W_OUT  <= W_OUT;
            OWNER  <= OWNER;
            GNT    <= GNT;
            init_r <= init_r;
        end
    end

    // Registered LOAD pulse (high exactly in the LOAD state) and sticky TIMEOUT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LOAD    <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            LOAD <= (state_s == S_LOAD);
            if (state_r == S_SEND && !DONE && tmo_hit_s) begin
                TIMEOUT <= 1'b1;
            end else begin
                TIMEOUT <= TIMEOUT;
            end
        end
    end

`ifdef FRAME_SCHED_STATS_EN
    // Saturating counts of completed frames and HOLD preemptions.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FRAME_CNT   <= 16'd0;
            PREEMPT_CNT <= 8'd0;
        end else begin
            if (state_r == S_SEND && DONE && FRAME_CNT != 16'hFFFF) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end else begin
                FRAME_CNT <= FRAME_CNT;
            end
            if (state_r == S_HOLD && preempt_s && PREEMPT_CNT != 8'hFF) begin
                PREEMPT_CNT <= PREEMPT_CNT + 8'd1;
            end else begin
                PREEMPT_CNT <= PREEMPT_CNT;
            end
        end
    end
`endif

endmodule
